// File: rtl/env_stream_manager.sv
// env_stream_manager
// Walks the obstacle table once per frame: advances oscillation phases, translates
// vertices, writes moving records back and streams every vertex over valid/ready.
// Optional feature: define ENV_FREEZE_EN to add freeze_in, which, when high on the
// start pulse, runs a write-free frame using the stored phases (paused-game view).
// INIT_FILE names the memory image the implementation flow preloads into the table.
module env_stream_manager #(
    parameter int WORLD_BITS       = 32,
    parameter int MAX_NUM_VERTICES = 8,
    parameter int DEPTH            = 128,
    parameter int DT               = 1,
    parameter     INIT_FILE        = "level.mem"
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  start_in,
    input  logic                  ready_in,
`ifdef ENV_FREEZE_EN
    input  logic                  freeze_in,
`endif
    output logic                  valid_out,
    output logic [WORLD_BITS-1:0] x_out,
    output logic [WORLD_BITS-1:0] y_out,
    output logic [7:0]            obj_id_out,
    output logic                  last_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out
);

    localparam int W  = WORLD_BITS;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(MAX_NUM_VERTICES + 1);
    localparam logic [AW:0]  ADDR_END = (AW + 1)'(DEPTH);
    localparam logic [W-1:0] MAX_N    = W'(MAX_NUM_VERTICES);
    localparam logic [W:0]   DT_EXT   = (W + 1)'(DT);

    typedef enum logic [2:0] {IDLE, RD_HDR, RD_PHASE, RD_VEL, RD_VERT, EMIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [AW:0]     addr_q, addr_d;
    logic            start_q, start_d;
    logic            freeze_q, freeze_d;
    logic            mode_q, mode_d;
    logic [CW-1:0]   nvert_q, nvert_d;
    logic [CW-1:0]   vidx_q, vidx_d;
    logic [W-1:0]    phase_q, phase_d;
    logic [W-1:0]    period_q, period_d;
    logic [W-1:0]    dx_q, dx_d;
    logic [W-1:0]    dy_q, dy_d;
    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic            last_q, last_d;
    logic [7:0]      obj_q, obj_d;
    logic            error_q, error_d;

    logic [2*W-1:0]  mem [DEPTH];
    logic [2*W-1:0]  rdata_q;
    logic            mem_re, mem_we;
    logic [AW-1:0]   mem_raddr, mem_waddr;
    logic [2*W-1:0]  mem_wdata;

    logic [W-1:0]    word_hi, word_lo;
    logic [AW:0]     next_addr;
    logic            addr_ok;
    logic [W:0]      phase_sum;
    logic [W-1:0]    phase_adv, phase_new;
    logic [W-1:0]    vert_x, vert_y;

    assign word_hi   = rdata_q[2*W-1:W];
    assign word_lo   = rdata_q[W-1:0];
    assign next_addr = addr_q + 1'b1;
    assign addr_ok   = (next_addr < ADDR_END);
    assign phase_sum = {1'b0, word_hi} + DT_EXT;
    assign phase_adv = (phase_sum >= {1'b0, word_lo}) ? W'(phase_sum - {1'b0, word_lo})
                                                      : phase_sum[W-1:0];
    assign phase_new = freeze_q ? word_hi : phase_adv;
    assign vert_x    = word_hi + dx_q;
    assign vert_y    = word_lo + dy_q;

    // Table memory: one synchronous read port and one write port, no reset.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) begin
            rdata_q <= mem[mem_raddr];
        end
    end

    // State register and datapath flops; reset aborts a frame but leaves memory alone.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            start_q  <= 1'b0;
            freeze_q <= 1'b0;
            mode_q   <= 1'b0;
            nvert_q  <= '0;
            vidx_q   <= '0;
            phase_q  <= '0;
            period_q <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            last_q   <= 1'b0;
            obj_q    <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            start_q  <= start_d;
            freeze_q <= freeze_d;
            mode_q   <= mode_d;
            nvert_q  <= nvert_d;
            vidx_q   <= vidx_d;
            phase_q  <= phase_d;
            period_q <= period_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            x_q      <= x_d;
            y_q      <= y_d;
            last_q   <= last_d;
            obj_q    <= obj_d;
            error_q  <= error_d;
        end
    end

    // Next-state, datapath and memory port control; each read is issued one state ahead.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        start_d   = 1'b0;
        freeze_d  = freeze_q;
        mode_d    = mode_q;
        nvert_d   = nvert_q;
        vidx_d    = vidx_q;
        phase_d   = phase_q;
        period_d  = period_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        x_d       = x_q;
        y_d       = y_q;
        last_d    = last_q;
        obj_d     = obj_q;
        error_d   = error_q;
        mem_re    = 1'b0;
        mem_raddr = next_addr[AW-1:0];
        mem_we    = 1'b0;
        mem_waddr = addr_q[AW-1:0];
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (start_q) begin
                    addr_d    = '0;
                    mem_re    = 1'b1;
                    mem_raddr = '0;
                    state_d   = RD_HDR;
                end else if (start_in) begin
                    start_d = 1'b1;
                    error_d = 1'b0;
                    obj_d   = '0;
`ifdef ENV_FREEZE_EN
                    freeze_d = freeze_in;
`else
                    freeze_d = 1'b0;
`endif
                end
            end
            RD_HDR: begin
                if (word_lo == '0) begin
                    state_d = DONE;
                end else if ((word_lo > MAX_N) || (word_hi > W'(1)) || !addr_ok) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    mode_d  = (word_hi == W'(1));
                    nvert_d = word_lo[CW-1:0];
                    vidx_d  = '0;
                    dx_d    = '0;
                    dy_d    = '0;
                    addr_d  = next_addr;
                    mem_re  = 1'b1;
                    state_d = (word_hi == W'(1)) ? RD_PHASE : RD_VERT;
                end
            end
            RD_PHASE: begin
                phase_d  = phase_new;
                period_d = word_lo;
                if ((word_lo != '0) && !freeze_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = {phase_new, word_lo};
                end
                if (!addr_ok) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = next_addr;
                    mem_re  = 1'b1;
                    state_d = RD_VEL;
                end
            end
            RD_VEL: begin
                if (period_q == '0) begin
                    dx_d = '0;
                    dy_d = '0;
                end else if (phase_q < (period_q >> 1)) begin
                    dx_d = word_hi;
                    dy_d = word_lo;
                end else begin
                    dx_d = -word_hi;
                    dy_d = -word_lo;
                end
                if (!addr_ok) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    addr_d  = next_addr;
                    mem_re  = 1'b1;
                    state_d = RD_VERT;
                end
            end
            RD_VERT: begin
                x_d    = vert_x;
                y_d    = vert_y;
                last_d = ((vidx_q + 1'b1) == nvert_q);
                vidx_d = vidx_q + 1'b1;
                if (mode_q && !freeze_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = {vert_x, vert_y};
                end
                state_d = EMIT;
            end
            EMIT: begin
                if (ready_in) begin
                    if (last_q) begin
                        obj_d = obj_q + 8'd1;
                    end
                    if (!addr_ok) begin
                        error_d = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = next_addr;
                        mem_re  = 1'b1;
                        state_d = last_q ? RD_HDR : RD_VERT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        valid_out = (state_q == EMIT);
        last_out  = (state_q == EMIT) && last_q;
        done_out  = (state_q == DONE);
        busy_out  = start_q || !((state_q == IDLE) || (state_q == DONE));
    end

    assign x_out      = x_q;
    assign y_out      = y_q;
    assign obj_id_out = obj_q;
    assign error_out  = error_q;

endmodule

// File: tb/tb_env_stream_manager.sv
// tb_env_stream_manager
// Directed self-checking bench for env_stream_manager (default build, no freeze port).
module tb_env_stream_manager;

    logic        clk_in;
    logic        rst_n_in;
    logic        start_in;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] x_out;
    logic [31:0] y_out;
    logic [7:0]  obj_id_out;
    logic        last_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    int tests_run;
    int tests_failed;

    logic signed [31:0] got_x [16];
    logic signed [31:0] got_y [16];
    logic               got_last [16];
    logic [7:0]         got_id [16];

    env_stream_manager dut (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .start_in   (start_in),
        .ready_in   (ready_in),
        .valid_out  (valid_out),
        .x_out      (x_out),
        .y_out      (y_out),
        .obj_id_out (obj_id_out),
        .last_out   (last_out),
        .busy_out   (busy_out),
        .done_out   (done_out),
        .error_out  (error_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [63:0] wd(input int a, input int b);
        return {a[31:0], b[31:0]};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 128; i++) dut.mem[i] <= '0;
        @(negedge clk_in);
    endtask

    // Pulses start and collects vertices until done_out; optionally stalls one vertex.
    task automatic run_frame(input int stall_idx, input int stall_len, output int n,
                             output int first, output bit done_seen, output int unstable);
        int cycles;
        int stall_left;
        logic [31:0] hx, hy;
        logic hl;
        hx = '0; hy = '0; hl = 1'b0;
        for (int i = 0; i < 16; i++) begin
            got_x[i] = 'x; got_y[i] = 'x; got_last[i] = 1'bx; got_id[i] = 'x;
        end
        n = 0; first = -1; done_seen = 1'b0; unstable = 0; cycles = 0; stall_left = stall_len;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        while (!done_seen && cycles < 1000) begin
            if (done_out) begin
                done_seen = 1'b1;
            end else if (valid_out) begin
                if (first < 0) first = cycles;
                if (n == stall_idx && stall_left > 0) begin
                    if (stall_left == stall_len) begin
                        hx = x_out; hy = y_out; hl = last_out;
                    end else if (x_out !== hx || y_out !== hy || last_out !== hl) begin
                        unstable++;
                    end
                    ready_in = 1'b0;
                    stall_left--;
                end else begin
                    if (n == stall_idx && stall_len > 0 &&
                        (x_out !== hx || y_out !== hy || last_out !== hl)) unstable++;
                    ready_in = 1'b1;
                    if (n < 16) begin
                        got_x[n] = x_out; got_y[n] = y_out;
                        got_last[n] = last_out; got_id[n] = obj_id_out;
                    end
                    n++;
                end
            end else begin
                ready_in = 1'b1;
            end
            if (!done_seen) begin
                @(negedge clk_in);
                cycles++;
            end
        end
        ready_in = 1'b1;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #2;
        tests_run++;
        if ({valid_out, last_out, busy_out, done_out, error_out} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b want 00000",
                     {valid_out, last_out, busy_out, done_out, error_out});
        end
        @(negedge clk_in);
        tests_run++;
        if (x_out !== 32'd0 || y_out !== 32'd0 || obj_id_out !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got x=%0d y=%0d id=%0d want 0 0 0",
                     x_out, y_out, obj_id_out);
        end
        @(negedge clk_in); rst_n_in = 1'b1;
        @(negedge clk_in);
    endtask

    task automatic test_static();
        int n, first, uns; bit dn;
        int ex[4], ey[4], eid[4];
        logic el[4];
        ex = '{0, 10, 0, -3}; ey = '{0, 0, 10, 7}; eid = '{0, 0, 0, 1};
        el = '{1'b0, 1'b0, 1'b1, 1'b1};
        clear_mem();
        dut.mem[0] <= wd(0, 3);
        dut.mem[1] <= wd(0, 0);
        dut.mem[2] <= wd(10, 0);
        dut.mem[3] <= wd(0, 10);
        dut.mem[4] <= wd(0, 1);
        dut.mem[5] <= wd(-3, 7);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 4) begin
            tests_failed++;
            $display("[TB] FAIL static_count: got done=%0b n=%0d want done=1 n=4", dn, n);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_x[i] !== ex[i] || got_y[i] !== ey[i] || got_last[i] !== el[i] ||
                got_id[i] !== eid[i][7:0]) begin
                tests_failed++;
                $display("[TB] FAIL static_v%0d: got (%0d,%0d) last=%b id=%0d want (%0d,%0d) last=%b id=%0d",
                         i, got_x[i], got_y[i], got_last[i], got_id[i], ex[i], ey[i], el[i], eid[i]);
            end
        end
        tests_run++;
        if (first < 3) begin
            tests_failed++;
            $display("[TB] FAIL static_latency: got first valid at %0d want >= 3", first);
        end
        tests_run++;
        if (dut.mem[2] !== wd(10, 0) || dut.mem[3] !== wd(0, 10) || error_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL static_mem: got mem2=%h mem3=%h err=%b want %h %h 0",
                     dut.mem[2], dut.mem[3], error_out, wd(10, 0), wd(0, 10));
        end
        @(negedge clk_in);
        tests_run++;
        if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL static_done_pulse: got done=%b busy=%b want 0 0", done_out, busy_out);
        end
    endtask

    task automatic load_square();
        clear_mem();
        dut.mem[0] <= wd(1, 4);
        dut.mem[1] <= wd(3, 8);
        dut.mem[2] <= wd(2, -1);
        dut.mem[3] <= wd(100, 100);
        dut.mem[4] <= wd(110, 100);
        dut.mem[5] <= wd(110, 110);
        dut.mem[6] <= wd(100, 110);
        @(negedge clk_in);
    endtask

    task automatic test_oscillate();
        int n, first, uns; bit dn;
        int ex1[4], ey1[4], ex2[4], ey2[4];
        ex1 = '{98, 108, 108, 98}; ey1 = '{101, 101, 111, 111};
        ex2 = '{96, 106, 106, 96}; ey2 = '{102, 102, 112, 112};
        load_square();
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 4 || first < 5) begin
            tests_failed++;
            $display("[TB] FAIL osc1_count: got done=%0b n=%0d first=%0d want 1 4 >=5", dn, n, first);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_x[i] !== ex1[i] || got_y[i] !== ey1[i] || got_last[i] !== (i == 3)) begin
                tests_failed++;
                $display("[TB] FAIL osc1_v%0d: got (%0d,%0d) last=%b want (%0d,%0d)",
                         i, got_x[i], got_y[i], got_last[i], ex1[i], ey1[i]);
            end
        end
        tests_run++;
        if (dut.mem[1] !== wd(4, 8) || dut.mem[3] !== wd(98, 101) || dut.mem[6] !== wd(98, 111)) begin
            tests_failed++;
            $display("[TB] FAIL osc1_mem: got %h %h %h want %h %h %h", dut.mem[1], dut.mem[3],
                     dut.mem[6], wd(4, 8), wd(98, 101), wd(98, 111));
        end
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 4) begin
            tests_failed++;
            $display("[TB] FAIL osc2_count: got done=%0b n=%0d want 1 4", dn, n);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_x[i] !== ex2[i] || got_y[i] !== ey2[i]) begin
                tests_failed++;
                $display("[TB] FAIL osc2_v%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, got_x[i], got_y[i], ex2[i], ey2[i]);
            end
        end
        tests_run++;
        if (dut.mem[1] !== wd(5, 8)) begin
            tests_failed++;
            $display("[TB] FAIL osc2_phase: got %h want %h", dut.mem[1], wd(5, 8));
        end
    endtask

    task automatic test_phase_wrap();
        int n, first, uns; bit dn;
        clear_mem();
        dut.mem[0] <= wd(1, 1);
        dut.mem[1] <= wd(7, 8);
        dut.mem[2] <= wd(3, 4);
        dut.mem[3] <= wd(20, 30);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 1 || got_x[0] !== 23 || got_y[0] !== 34 || got_last[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL wrap_vertex: got n=%0d (%0d,%0d) last=%b want 1 (23,34) 1",
                     n, got_x[0], got_y[0], got_last[0]);
        end
        tests_run++;
        if (dut.mem[1] !== wd(0, 8) || dut.mem[3] !== wd(23, 34)) begin
            tests_failed++;
            $display("[TB] FAIL wrap_mem: got %h %h want %h %h", dut.mem[1], dut.mem[3],
                     wd(0, 8), wd(23, 34));
        end
    endtask

    task automatic test_back_to_back();
        int n, first, uns; bit dn;
        int ex[3], ey[3];
        ex = '{1, 51, -4}; ey = '{1, 61, -4};
        clear_mem();
        dut.mem[0] <= wd(1, 3);
        dut.mem[1] <= wd(0, 8);
        dut.mem[2] <= wd(1, 1);
        dut.mem[3] <= wd(0, 0);
        dut.mem[4] <= wd(50, 60);
        dut.mem[5] <= wd(-5, -5);
        @(negedge clk_in);
        run_frame(1, 5, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 3 || uns != 0) begin
            tests_failed++;
            $display("[TB] FAIL stall_stream: got done=%0b n=%0d unstable=%0d want 1 3 0", dn, n, uns);
        end
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (got_x[i] !== ex[i] || got_y[i] !== ey[i] || got_last[i] !== (i == 2)) begin
                tests_failed++;
                $display("[TB] FAIL stall_v%0d: got (%0d,%0d) last=%b want (%0d,%0d)",
                         i, got_x[i], got_y[i], got_last[i], ex[i], ey[i]);
            end
        end
        tests_run++;
        if (dut.mem[1] !== wd(1, 8) || dut.mem[4] !== wd(51, 61) || dut.mem[5] !== wd(-4, -4)) begin
            tests_failed++;
            $display("[TB] FAIL stall_mem: got %h %h %h want %h %h %h", dut.mem[1], dut.mem[4],
                     dut.mem[5], wd(1, 8), wd(51, 61), wd(-4, -4));
        end
    endtask

    task automatic test_max_vertices();
        int n, first, uns; bit dn;
        clear_mem();
        dut.mem[0] <= wd(0, 8);
        for (int i = 0; i < 8; i++) dut.mem[1 + i] <= wd(i, 2 * i);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 8 || error_out !== 1'b0 || got_last[7] !== 1'b1 || got_last[6] !== 1'b0 ||
            got_x[7] !== 7 || got_y[7] !== 14) begin
            tests_failed++;
            $display("[TB] FAIL max_n: got n=%0d err=%b last6=%b last7=%b v7=(%0d,%0d) want 8 0 0 1 (7,14)",
                     n, error_out, got_last[6], got_last[7], got_x[7], got_y[7]);
        end
    endtask

    task automatic test_errors();
        int n, first, uns; bit dn;
        clear_mem();
        dut.mem[0] <= wd(0, 9);
        dut.mem[1] <= wd(1, 1);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 0 || error_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_too_many: got done=%0b n=%0d err=%b want 1 0 1", dn, n, error_out);
        end
        dut.mem[0] <= wd(0, 0);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 0 || error_out !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL err_clear: got done=%0b n=%0d err=%b want 1 0 0", dn, n, error_out);
        end
        dut.mem[0] <= wd(5, 2);
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 0 || error_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_mode: got done=%0b n=%0d err=%b want 1 0 1", dn, n, error_out);
        end
        for (int k = 0; k < 64; k++) begin
            dut.mem[2 * k]     <= wd(0, 1);
            dut.mem[2 * k + 1] <= wd(k, k + 1);
        end
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 64 || error_out !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL err_addr_end: got done=%0b n=%0d err=%b want 1 64 1", dn, n, error_out);
        end
    endtask

    task automatic test_midframe_reset();
        int n, first, uns, hs, cyc; bit dn;
        int ex[4], ey[4];
        ex = '{96, 106, 106, 98}; ey = '{102, 102, 112, 111};
        load_square();
        ready_in = 1'b1;
        @(negedge clk_in); start_in = 1'b1;
        @(negedge clk_in); start_in = 1'b0;
        hs = 0; cyc = 0;
        while (cyc < 200) begin
            if (valid_out) begin
                if (hs == 2) break;
                hs++;
            end
            @(negedge clk_in);
            cyc++;
        end
        tests_run++;
        if (cyc >= 200) begin
            tests_failed++;
            $display("[TB] FAIL midreset_reach: third vertex not seen, handshakes=%0d want 2", hs);
        end
        rst_n_in = 1'b0;
        #1;
        tests_run++;
        if ({valid_out, last_out, busy_out, done_out, error_out} !== 5'b0 ||
            x_out !== 32'd0 || y_out !== 32'd0 || obj_id_out !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: got flags=%b x=%0d y=%0d id=%0d want 0",
                     {valid_out, last_out, busy_out, done_out, error_out}, x_out, y_out, obj_id_out);
        end
        @(negedge clk_in); rst_n_in = 1'b1;
        @(negedge clk_in);
        run_frame(-1, 0, n, first, dn, uns);
        tests_run++;
        if (!dn || n != 4) begin
            tests_failed++;
            $display("[TB] FAIL midreset_count: got done=%0b n=%0d want 1 4", dn, n);
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (got_x[i] !== ex[i] || got_y[i] !== ey[i]) begin
                tests_failed++;
                $display("[TB] FAIL midreset_v%0d: got (%0d,%0d) want (%0d,%0d)",
                         i, got_x[i], got_y[i], ex[i], ey[i]);
            end
        end
        tests_run++;
        if (dut.mem[1] !== wd(5, 8)) begin
            tests_failed++;
            $display("[TB] FAIL midreset_phase: got %h want %h", dut.mem[1], wd(5, 8));
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        start_in     = 1'b0;
        ready_in     = 1'b1;
        rst_n_in     = 1'b0;
        test_reset();
        test_static();
        test_oscillate();
        test_phase_wrap();
        test_back_to_back();
        test_max_vertices();
        test_errors();
        test_midframe_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
